// File: rtl/soc_top_pkg.sv
// -----------------------------------------------------------------------------
// soc_top_pkg
// Shared constants and types for the interrupt front-end:
//   N_IRQ_DEF, SERVICE_CYCLES_DEF, CNT_W_DEF : default parameter values
//   ID_W                                     : width of a line index
//   svc_state_e                              : service slot FSM states
//   cnt_width()                              : width for a 0..n-1 counter
// -----------------------------------------------------------------------------
package soc_top_pkg;

    localparam int N_IRQ_DEF          = 31;
    localparam int SERVICE_CYCLES_DEF = 8;
    localparam int CNT_W_DEF          = 16;
    localparam int ID_W               = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } svc_state_e;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/soc_top_if.sv
// -----------------------------------------------------------------------------
// soc_top_if
// Status bundle published by the interrupt front-end.
//   irq_pending    : per-line pending flags
//   irq_lost       : sticky per-line overflow flags
//   in_service     : service slot busy
//   service_id     : line currently / last serviced
//   irq_ack        : one-cycle dispatch pulse
//   serviced_count : dispatches since reset (wrapping)
// master: the front-end (drives); slave: observers (read).
// -----------------------------------------------------------------------------
interface soc_top_if
    import soc_top_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic [N_IRQ-1:0] irq_pending;
    logic [N_IRQ-1:0] irq_lost;
    logic             in_service;
    logic [ID_W-1:0]  service_id;
    logic             irq_ack;
    logic [CNT_W-1:0] serviced_count;

    modport master (
        output irq_pending,
        output irq_lost,
        output in_service,
        output service_id,
        output irq_ack,
        output serviced_count
    );

    modport slave (
        input irq_pending,
        input irq_lost,
        input in_service,
        input service_id,
        input irq_ack,
        input serviced_count
    );

endinterface

// File: rtl/irq_edge_capture.sv
// -----------------------------------------------------------------------------
// irq_edge_capture
// Captures rising edges of one asynchronous interrupt line, including pulses
// shorter than a Clk period, and presents them as a Clk-domain event.
//   Clk   : system clock
//   Rst   : synchronous active-low reset
//   i_irq : raw asynchronous interrupt line
//   o_evt : high for one Clk cycle per captured edge
// -----------------------------------------------------------------------------
module irq_edge_capture (
    input  logic Clk,
    input  logic Rst,
    input  logic i_irq,
    output logic o_evt
);

    logic r_tog;
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Toggle on every rising edge of the line; the change of level is what
    // crosses into Clk, so arbitrarily short pulses are not missed.
    always_ff @(posedge i_irq) begin
        r_tog <= ~r_tog;
    end

    // Two-flop synchronizer plus previous-value register. Under reset all
    // three load the current toggle level so no event is seen on release.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_sync1 <= r_tog;
            r_sync2 <= r_tog;
            r_prev  <= r_tog;
        end else begin
            r_sync1 <= r_tog;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_evt = r_sync2 ^ r_prev;

endmodule

// File: rtl/soc_top.sv
// -----------------------------------------------------------------------------
// soc_top
// Interrupt front-end: captures N_IRQ asynchronous edge-triggered lines,
// keeps pending/lost flags and dispatches the lowest-index pending line into
// a fixed-length service window.
//   Clk   : system clock
//   Rst   : synchronous active-low reset
//   i_ext : external interrupt lines (asynchronous, rising-edge)
//   o_irq : status bundle (pending, lost, in_service, service_id, irq_ack,
//           serviced_count)
// -----------------------------------------------------------------------------
module soc_top
    import soc_top_pkg::*;
#(
    parameter int N_IRQ          = N_IRQ_DEF,
    parameter int SERVICE_CYCLES = SERVICE_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_IRQ-1:0] i_ext,
    soc_top_if.master        o_irq
);

    localparam int              BC_W    = cnt_width(SERVICE_CYCLES);
    localparam logic [BC_W-1:0] LAST_BC = BC_W'(SERVICE_CYCLES - 1);

    logic [N_IRQ-1:0] w_evt;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_pend_nxt;
    logic [N_IRQ-1:0] w_lost_nxt;
    logic [ID_W-1:0]  w_idx;
    logic             w_dispatch;
    logic [BC_W-1:0]  w_bcnt_nxt;
    logic [ID_W-1:0]  w_id_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    svc_state_e       w_state_nxt;

    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_lost;
    logic             r_in_service;
    logic [ID_W-1:0]  r_service_id;
    logic             r_ack;
    logic [CNT_W-1:0] r_count;
    logic [BC_W-1:0]  r_bcnt;
    svc_state_e       r_state;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_cap
        irq_edge_capture u_cap (
            .Clk   (Clk),
            .Rst   (Rst),
            .i_irq (i_ext[g]),
            .o_evt (w_evt[g])
        );
    end

    // Priority encoder: scanning downwards leaves the lowest set index.
    always_comb begin
        w_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            w_idx = r_pending[i] ? ID_W'(i) : w_idx;
        end
    end

    // Service FSM next state, dispatch decision and busy-cycle counter.
    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        w_bcnt_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = BUSY;
                    w_dispatch  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_bcnt == LAST_BC) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = BUSY;
                    w_bcnt_nxt  = r_bcnt + BC_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pending/lost update: a new event on the line being dispatched re-arms
    // it (set wins) rather than counting as lost.
    always_comb begin
        w_clr       = '0;
        w_id_nxt    = r_service_id;
        w_count_nxt = r_count;
        if (w_dispatch) begin
            w_clr       = N_IRQ'(1'b1) << w_idx;
            w_id_nxt    = w_idx;
            w_count_nxt = r_count + CNT_W'(1);
        end else begin
            w_clr       = '0;
        end
        w_pend_nxt = (r_pending & ~w_clr) | w_evt;
        w_lost_nxt = r_lost | (w_evt & r_pending & ~w_clr);
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state      <= IDLE;
            r_bcnt       <= '0;
            r_pending    <= '0;
            r_lost       <= '0;
            r_in_service <= 1'b0;
            r_service_id <= '0;
            r_ack        <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_pending    <= w_pend_nxt;
            r_lost       <= w_lost_nxt;
            r_in_service <= (w_state_nxt == BUSY);
            r_service_id <= w_id_nxt;
            r_ack        <= w_dispatch;
            r_count      <= w_count_nxt;
        end
    end

    assign o_irq.irq_pending    = r_pending;
    assign o_irq.irq_lost       = r_lost;
    assign o_irq.in_service     = r_in_service;
    assign o_irq.service_id     = r_service_id;
    assign o_irq.irq_ack        = r_ack;
    assign o_irq.serviced_count = r_count;

endmodule

// File: tb/tb_soc_top.sv
// -----------------------------------------------------------------------------
// tb_soc_top
// Drives short asynchronous pulses on the interrupt lines and compares every
// cycle against a reference model that tracks pending/lost masks, the
// remaining service time and the dispatch count.
// -----------------------------------------------------------------------------
module tb_soc_top;

    localparam int NI = 31;
    localparam int SC = 8;
    localparam int CW = 4;
    localparam int AR = 8192;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic [NI-1:0] i_ext = '0;

    soc_top_if #(.N_IRQ(NI), .CNT_W(CW)) u_if ();

    soc_top #(
        .N_IRQ          (NI),
        .SERVICE_CYCLES (SC),
        .CNT_W          (CW)
    ) u_dut (
        .Clk   (clk),
        .Rst   (rst),
        .i_ext (i_ext),
        .o_irq (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    logic [NI-1:0] arrive [0:AR-1];  // events taking effect at a given edge
    logic [NI-1:0] m_pend  = '0;
    logic [NI-1:0] m_lost  = '0;
    int            m_left  = 0;      // service cycles still to run
    logic          m_ack   = 1'b0;
    int            m_id    = 0;
    int            m_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model across one rising Clk edge.
    task automatic model_step();
        logic [NI-1:0] ev;
        logic [NI-1:0] clr;
        int            idx;
        if (!rst) begin
            m_pend  = '0;
            m_lost  = '0;
            m_left  = 0;
            m_ack   = 1'b0;
            m_id    = 0;
            m_count = 0;
            // events still inside the synchronizer are swallowed by reset
            for (int j = 0; j < 3; j++) begin
                if (cyc + j < AR) arrive[cyc + j] = '0;
            end
        end else begin
            ev    = (cyc < AR) ? arrive[cyc] : '0;
            clr   = '0;
            m_ack = 1'b0;
            if (m_left == 0 && m_pend != '0) begin
                idx = 0;
                while (!m_pend[idx]) idx++;
                clr[idx] = 1'b1;
                m_ack    = 1'b1;
                m_id     = idx;
                m_count  = (m_count + 1) % (1 << CW);
                m_left   = SC;
            end else if (m_left > 0) begin
                m_left--;
            end
            m_lost = m_lost | (ev & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | ev;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("pending",    64'(u_if.irq_pending),    64'(m_pend));
        chk("lost",       64'(u_if.irq_lost),       64'(m_lost));
        chk("in_service", 64'(u_if.in_service),     64'(m_left > 0));
        chk("service_id", 64'(u_if.service_id),     64'(m_id));
        chk("irq_ack",    64'(u_if.irq_ack),        64'(m_ack));
        chk("count",      64'(u_if.serviced_count), 64'(m_count));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // 2 ns pulse placed mid-cycle; takes effect three edges later.
    task automatic pulse(input logic [NI-1:0] m);
        #2;
        i_ext = m;
        #2;
        i_ext = '0;
        if (cyc + 3 < AR) arrive[cyc + 3] = arrive[cyc + 3] | m;
    endtask

    initial begin
        logic [NI-1:0] m;
        for (int i = 0; i < AR; i++) arrive[i] = '0;

        // reset with line activity
        rst = 1'b0;
        pulse(NI'($urandom()));
        tick();
        pulse(NI'($urandom()));
        tick();
        rst = 1'b1;
        run(4);

        // short pulse on line 1
        pulse(NI'(1) << 1);
        run(15);

        // same-line re-arm: second event lands on the dispatch edge
        pulse(NI'(1) << 1);
        tick();
        pulse(NI'(1) << 1);
        run(25);

        // lost event on line 5 while line 0 is in service
        pulse(NI'(1));
        run(4);
        pulse(NI'(1) << 5);
        run(2);
        pulse(NI'(1) << 5);
        run(2);
        pulse(NI'(1) << 5);
        run(25);

        // priority: 7 and 2 together while busy
        pulse(NI'(1));
        run(4);
        pulse((NI'(1) << 7) | (NI'(1) << 2));
        run(30);

        // reset in the middle of a service
        pulse(NI'(1) << 3);
        run(6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run(5);

        // counter wrap: 17 dispatches on a 4-bit counter
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 17; k++) begin
            pulse(NI'(1) << $urandom_range(0, NI - 1));
            run(SC + 3);
        end
        run(6);
        chk("wrap_count", 64'(u_if.serviced_count), 64'(1));

        // randomized traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                m = NI'(1) << $urandom_range(0, NI - 1);
                if ($urandom_range(0, 2) == 0) m = m | (NI'(1) << $urandom_range(0, NI - 1));
                pulse(m);
            end
            tick();
        end
        rst = 1'b1;
        run(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
